// File: rtl/control_pkg.sv
// Shared decode constants for the control unit: opcodes, ALU operation codes,
// writeback select codes and the registered control bundle.
package control_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } result_src_e;

  // Which funct3 interpretation the ALU decoder applies.
  typedef enum logic [1:0] {
    CLS_ADD    = 2'b00,
    CLS_RTYPE  = 2'b01,
    CLS_ITYPE  = 2'b10,
    CLS_BRANCH = 2'b11
  } alu_class_e;

  typedef struct packed {
    alu_op_e     alu_control;
    logic        reg_write_en;
    logic        mem_write_en;
    logic        mem_read_en;
    result_src_e result_src;
    logic        alu_src;
    logic        pc_src;
    logic        branch;
  } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational map from opcode class, funct3 and funct7[5] to the ALU
// operation code.
module alu_decoder
  import control_pkg::*;
(
  input  alu_class_e cls_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output alu_op_e    alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (cls_i)
      CLS_RTYPE, CLS_ITYPE: begin
        case (funct3_i)
          3'b000: alu_control_o = (cls_i == CLS_RTYPE && funct7_5_i) ? ALU_SUB : ALU_ADD;
          3'b001: alu_control_o = ALU_SLL;
          3'b010: alu_control_o = ALU_SLT;
          3'b011: alu_control_o = ALU_SLTU;
          3'b100: alu_control_o = ALU_XOR;
          3'b101: alu_control_o = funct7_5_i ? ALU_SRA : ALU_SRL;
          3'b110: alu_control_o = ALU_OR;
          3'b111: alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      CLS_BRANCH: begin
        // Equality compares use SUB, ordered compares use SLT/SLTU.
        case (funct3_i[2:1])
          2'b00:   alu_control_o = ALU_SUB;
          2'b10:   alu_control_o = ALU_SLT;
          2'b11:   alu_control_o = ALU_SLTU;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Main instruction decoder with a single registered output stage; outputs
// clear asynchronously while rst_n is low.
module control_unit
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_control,
  output logic       reg_write_en,
  output logic       mem_write_en,
  output logic       mem_read_en,
  output logic [1:0] result_src,
  output logic       alu_src,
  output logic       pc_src,
  output logic       branch
);

  alu_class_e cls;
  alu_op_e    alu_op;
  ctrl_t      ctrl_d;
  ctrl_t      ctrl_q;
  logic       legal;

  always_comb begin
    cls = CLS_ADD;
    case (opcode)
      OP_RTYPE:  cls = CLS_RTYPE;
      OP_ITYPE:  cls = CLS_ITYPE;
      OP_BRANCH: cls = CLS_BRANCH;
      default:   cls = CLS_ADD;
    endcase
  end

  alu_decoder u_alu_decoder (
    .cls_i        (cls),
    .funct3_i     (funct3),
    .funct7_5_i   (funct7[5]),
    .alu_control_o(alu_op)
  );

  always_comb begin
    ctrl_d = '0;
    legal  = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        ctrl_d.reg_write_en = 1'b1;
      end
      OP_ITYPE: begin
        ctrl_d.reg_write_en = 1'b1;
        ctrl_d.alu_src      = 1'b1;
      end
      OP_LOAD: begin
        ctrl_d.reg_write_en = 1'b1;
        ctrl_d.mem_read_en  = 1'b1;
        ctrl_d.alu_src      = 1'b1;
        ctrl_d.result_src   = RES_MEM;
      end
      OP_STORE: begin
        ctrl_d.mem_write_en = 1'b1;
        ctrl_d.alu_src      = 1'b1;
      end
      OP_BRANCH: begin
        // funct3 010/011 are not branch encodings.
        legal         = (funct3[2:1] != 2'b01);
        ctrl_d.branch = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        ctrl_d.reg_write_en = 1'b1;
        ctrl_d.pc_src       = 1'b1;
        ctrl_d.alu_src      = 1'b1;
        ctrl_d.result_src   = RES_PC4;
      end
      OP_LUI: begin
        ctrl_d.reg_write_en = 1'b1;
        ctrl_d.alu_src      = 1'b1;
        ctrl_d.result_src   = RES_IMM;
      end
      OP_AUIPC: begin
        ctrl_d.reg_write_en = 1'b1;
        ctrl_d.alu_src      = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    ctrl_d.alu_control = alu_op;
    if (!legal) ctrl_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctrl_q <= '0;
    else        ctrl_q <= ctrl_d;
  end

  assign alu_control  = ctrl_q.alu_control;
  assign reg_write_en = ctrl_q.reg_write_en;
  assign mem_write_en = ctrl_q.mem_write_en;
  assign mem_read_en  = ctrl_q.mem_read_en;
  assign result_src   = ctrl_q.result_src;
  assign alu_src      = ctrl_q.alu_src;
  assign pc_src       = ctrl_q.pc_src;
  assign branch       = ctrl_q.branch;

endmodule

// File: tb/tb_control_unit.sv
// Directed and randomized bench for control_unit, compared against a
// table-driven instruction decode model.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic [3:0] alu_control;
  logic       reg_write_en, mem_write_en, mem_read_en;
  logic [1:0] result_src;
  logic       alu_src, pc_src, branch;
  logic [11:0] obs;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7),
    .alu_control (alu_control),
    .reg_write_en(reg_write_en),
    .mem_write_en(mem_write_en),
    .mem_read_en (mem_read_en),
    .result_src  (result_src),
    .alu_src     (alu_src),
    .pc_src      (pc_src),
    .branch      (branch)
  );

  assign obs = {alu_control, reg_write_en, mem_write_en, mem_read_en,
                result_src, alu_src, pc_src, branch};

  // Expected {alu_control, rw, mw, mr, result_src, alu_src, pc_src, branch}.
  function automatic logic [11:0] model(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7);
    logic [3:0] ftab [8];
    logic [3:0] alu;
    logic       rw, mw, mr, as, pc, br;
    logic [1:0] rs;
    ftab = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
    alu = 4'd0; rw = 0; mw = 0; mr = 0; as = 0; pc = 0; br = 0; rs = 2'd0;
    case (op)
      7'h33: begin
        rw = 1; alu = ftab[f3];
        if (f7[5] && f3 == 3'd0) alu = 4'd1;
        if (f7[5] && f3 == 3'd5) alu = 4'd7;
      end
      7'h13: begin
        rw = 1; as = 1; alu = ftab[f3];
        if (f7[5] && f3 == 3'd5) alu = 4'd7;
      end
      7'h03: begin rw = 1; mr = 1; as = 1; rs = 2'd1; end
      7'h23: begin mw = 1; as = 1; end
      7'h63: begin
        if (f3 != 3'd2 && f3 != 3'd3) begin
          br = 1;
          alu = (f3 < 3'd2) ? 4'd1 : (f3 < 3'd6) ? 4'd8 : 4'd9;
        end
      end
      7'h6f, 7'h67: begin rw = 1; pc = 1; rs = 2'd2; as = 1; end
      7'h37: begin rw = 1; rs = 2'd3; as = 1; end
      7'h17: begin rw = 1; as = 1; end
      default: ;
    endcase
    return {alu, rw, mw, mr, rs, as, pc, br};
  endfunction

  task automatic check(input string tag, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_invariants(input string tag);
    checks++;
    assert (!(mem_write_en && mem_read_en) && !(pc_src && branch)) else begin
      failures++;
      $error("FAIL %s observed mw=%b mr=%b pc=%b br=%b expected no conflicting pair",
             tag, mem_write_en, mem_read_en, pc_src, branch);
    end
  endtask

  task automatic step(input string tag, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7);
    @(negedge clk);
    opcode = op; funct3 = f3; funct7 = f7;
    @(posedge clk);
    #1;
    check(tag, model(op, f3, f7));
  endtask

  initial begin
    logic [6:0] ops [10];
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h7f};

    // Reset held from time zero with a live instruction on the inputs.
    opcode = 7'h33; funct3 = 3'd4; funct7 = 7'h00;
    #2;
    check("reset_t0", 12'h000);
    @(posedge clk); #1;
    check("reset_hold_edge", 12'h000);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_edge_after_reset", model(7'h33, 3'd4, 7'h00));

    step("r_add", 7'h33, 3'd0, 7'h00);
    step("r_sub", 7'h33, 3'd0, 7'h20);
    step("r_sra", 7'h33, 3'd5, 7'h20);
    step("addi_not_sub", 7'h13, 3'd0, 7'h20);
    step("srai", 7'h13, 3'd5, 7'h20);
    step("lw", 7'h03, 3'd2, 7'h00);
    step("sw", 7'h23, 3'd2, 7'h00);
    step("beq", 7'h63, 3'd0, 7'h00);
    step("bltu", 7'h63, 3'd6, 7'h00);
    step("branch_illegal_f3", 7'h63, 3'd2, 7'h00);
    step("jal", 7'h6f, 3'd0, 7'h00);
    step("jalr", 7'h67, 3'd0, 7'h00);
    step("lui", 7'h37, 3'd3, 7'h7f);
    step("auipc", 7'h17, 3'd1, 7'h00);
    step("unknown_op", 7'h7f, 3'd0, 7'h00);

    // Inputs changing between edges must not reach the outputs.
    step("lw_before_change", 7'h03, 3'd0, 7'h00);
    @(negedge clk);
    opcode = 7'h23; funct3 = 3'd2; funct7 = 7'h00;
    #1;
    check("hold_between_edges", model(7'h03, 3'd0, 7'h00));
    @(posedge clk); #1;
    check("sw_after_edge", model(7'h23, 3'd2, 7'h00));

    // Asynchronous reset mid-cycle, held across an edge, then released.
    step("jal_before_reset", 7'h6f, 3'd0, 7'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_cycle", 12'h000);
    @(posedge clk); #1;
    check("async_reset_over_edge", 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reload_after_reset", model(7'h6f, 3'd0, 7'h00));

    for (int i = 0; i < 300; i++) begin
      op = ops[$urandom_range(0, 9)];
      if (op == 7'h7f) op = 7'($urandom);
      f3 = 3'($urandom);
      f7 = 7'($urandom);
      step("random", op, f3, f7);
      check_invariants("random_invariant");
      if ($urandom_range(0, 15) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("random_async_reset", 12'h000);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
